// File: rtl/cpu_clk_ctrl.sv
// CPU clock generator: divides clk50M by a runtime ratio, with halt and debounced single-step modes.
// Define CPU_CLK_CYCLE_CNT_EN to build the 32-bit cycle_count register; otherwise it is tied to 0.
module cpu_clk_ctrl #(
    parameter int CNT_WIDTH  = 26,
    parameter int DEB_CYCLES = 500000,
    parameter int DEB_WIDTH  = 20
) (
    input  logic                 clk50M,
    input  logic                 rst,
    input  logic [CNT_WIDTH-1:0] speed,
    input  logic [1:0]           mode,
    input  logic                 step_btn,
    output logic                 clk_cpu,
    output logic                 rise_tick,
    output logic [31:0]          cycle_count
);

    localparam logic [2:0] ST_RUN     = 3'd0;
    localparam logic [2:0] ST_DRAIN   = 3'd1;
    localparam logic [2:0] ST_IDLE    = 3'd2;
    localparam logic [2:0] ST_STEP_HI = 3'd3;
    localparam logic [2:0] ST_STEP_LO = 3'd4;

    localparam logic [1:0] MODE_STEP = 2'b01;
    localparam logic [1:0] MODE_HALT = 2'b10;

    localparam logic [DEB_WIDTH-1:0] DEB_LAST = DEB_WIDTH'(DEB_CYCLES - 1);

    logic [2:0]           state, state_nxt;
    logic [CNT_WIDTH-1:0] cnt, cnt_nxt, cnt_inc, div_cnt;
    logic                 clk_nxt, div_clk, term, rise_nxt;
    logic                 run_mode, step_mode, halt_mode;

    logic [1:0]           sync;
    logic [DEB_WIDTH-1:0] deb_cnt;
    logic                 deb_level, deb_level_d, press;

    // Mode 11 is deliberately folded into run.
    assign step_mode = (mode == MODE_STEP);
    assign halt_mode = (mode == MODE_HALT);
    assign run_mode  = !step_mode && !halt_mode;

    // >= lets a speed decrease below the running count end the phase at once.
    assign term    = (cnt >= speed);
    assign cnt_inc = cnt + CNT_WIDTH'(1);
    assign div_cnt = term ? '0 : cnt_inc;
    assign div_clk = term ? ~clk_cpu : clk_cpu;

    always_comb begin
        // NOTE: defaults first so every path assigns every signal; no latches are inferred.
        state_nxt = state;
        cnt_nxt   = cnt;
        clk_nxt   = clk_cpu;
        case (state)
            ST_RUN: begin
                if (run_mode) begin
                    cnt_nxt = div_cnt;
                    clk_nxt = div_clk;
                end else if (!clk_cpu || term) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                    clk_nxt   = 1'b0;
                end else begin
                    state_nxt = ST_DRAIN;
                    cnt_nxt   = cnt_inc;
                end
            end
            ST_DRAIN: begin
                if (run_mode) begin
                    state_nxt = ST_RUN;
                    cnt_nxt   = div_cnt;
                    clk_nxt   = div_clk;
                end else if (term) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                    clk_nxt   = 1'b0;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            ST_IDLE: begin
                cnt_nxt = '0;
                clk_nxt = 1'b0;
                if (run_mode) begin
                    state_nxt = ST_RUN;
                end else if (step_mode && press) begin
                    state_nxt = ST_STEP_HI;
                    clk_nxt   = 1'b1;
                end
            end
            ST_STEP_HI: begin
                if (run_mode) begin
                    state_nxt = ST_RUN;
                    cnt_nxt   = div_cnt;
                    clk_nxt   = div_clk;
                end else if (term) begin
                    state_nxt = halt_mode ? ST_IDLE : ST_STEP_LO;
                    cnt_nxt   = '0;
                    clk_nxt   = 1'b0;
                end else begin
                    state_nxt = halt_mode ? ST_DRAIN : ST_STEP_HI;
                    cnt_nxt   = cnt_inc;
                end
            end
            ST_STEP_LO: begin
                if (run_mode) begin
                    state_nxt = ST_RUN;
                    cnt_nxt   = div_cnt;
                    clk_nxt   = div_clk;
                end else if (halt_mode || term) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            default: begin
                state_nxt = ST_RUN;
                cnt_nxt   = '0;
                clk_nxt   = 1'b0;
            end
        endcase
    end

    assign rise_nxt = clk_nxt & ~clk_cpu;

    always_ff @(posedge clk50M or negedge rst) begin
        if (!rst) begin
            state     <= ST_RUN;
            cnt       <= '0;
            clk_cpu   <= 1'b0;
            rise_tick <= 1'b0;
        end else begin
            // NOTE: non-blocking for all flops so every register samples pre-edge values.
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            clk_cpu   <= clk_nxt;
            rise_tick <= rise_nxt;
        end
    end

    // Button path: synchroniser, debouncer, then a one-cycle press pulse on the debounced rise.
    always_ff @(posedge clk50M or negedge rst) begin
        if (!rst) begin
            sync        <= 2'b00;
            deb_cnt     <= '0;
            deb_level   <= 1'b0;
            deb_level_d <= 1'b0;
            press       <= 1'b0;
        end else begin
            sync <= {sync[0], step_btn};
            if (sync[1] == deb_level) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                deb_cnt   <= '0;
                deb_level <= ~deb_level;
            end else begin
                deb_cnt <= deb_cnt + DEB_WIDTH'(1);
            end
            deb_level_d <= deb_level;
            press       <= deb_level & ~deb_level_d;
        end
    end

`ifdef CPU_CLK_CYCLE_CNT_EN
    always_ff @(posedge clk50M or negedge rst) begin
        if (!rst) begin
            cycle_count <= 32'd0;
        end else if (rise_nxt) begin
            cycle_count <= cycle_count + 32'd1;
        end
    end
`else
    assign cycle_count = 32'd0;
`endif

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Self-checking bench for cpu_clk_ctrl: a scoreboard of expected clk_cpu edges (cycle, value)
// filled by each scenario and drained by a negedge monitor.
module tb_cpu_clk_ctrl;

    localparam int CW = 26;

    typedef struct {
        int   cyc;
        logic val;
    } ev_t;

    logic          clk50M;
    logic          rst;
    logic [CW-1:0] speed;
    logic [1:0]    mode;
    logic          step_btn;
    logic          clk_cpu;
    logic          rise_tick;
    logic [31:0]   cycle_count;

    int   pcyc       = 0;
    int   total      = 0;
    int   bad        = 0;
    int   rises_seen = 0;
    logic sb_on      = 1'b0;
    logic prev_clk   = 1'b0;
    ev_t  exp_q[$];

    cpu_clk_ctrl #(
        .CNT_WIDTH (CW),
        .DEB_CYCLES(8),
        .DEB_WIDTH (4)
    ) dut (
        .clk50M     (clk50M),
        .rst        (rst),
        .speed      (speed),
        .mode       (mode),
        .step_btn   (step_btn),
        .clk_cpu    (clk_cpu),
        .rise_tick  (rise_tick),
        .cycle_count(cycle_count)
    );

    initial begin
        clk50M = 1'b0;
        forever #5 clk50M = ~clk50M;
    end

    always @(posedge clk50M) pcyc <= pcyc + 1;

    function automatic logic [31:0] cnt_model(input int n);
`ifdef CPU_CLK_CYCLE_CNT_EN
        return 32'(n);
`else
        return 32'd0;
`endif
    endfunction

    // Monitor: every clk_cpu change must match the head of the scoreboard.
    always @(negedge clk50M) begin
        ev_t  ev;
        logic exp_rt;
        if (sb_on) begin
            if (clk_cpu !== prev_clk) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL clk_edge: clk_cpu=%b at cyc %0d, expected no edge", clk_cpu, pcyc);
                end else begin
                    ev = exp_q.pop_front();
                    if (ev.cyc != pcyc || ev.val !== clk_cpu) begin
                        bad++;
                        $display("FAIL clk_edge: clk_cpu=%b at cyc %0d, expected %b at cyc %0d",
                                 clk_cpu, pcyc, ev.val, ev.cyc);
                    end
                end
                if (clk_cpu === 1'b1) rises_seen++;
            end
            exp_rt = (clk_cpu === 1'b1) && (prev_clk === 1'b0);
            total++;
            if (rise_tick !== exp_rt) begin
                bad++;
                $display("FAIL rise_tick: got %b at cyc %0d, expected %b", rise_tick, pcyc, exp_rt);
            end
            total++;
            if (cycle_count !== cnt_model(rises_seen)) begin
                bad++;
                $display("FAIL cycle_count: got %0d at cyc %0d, expected %0d",
                         cycle_count, pcyc, cnt_model(rises_seen));
            end
        end
        prev_clk = clk_cpu;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push_ev(input int c, input logic v);
        exp_q.push_back('{cyc: c, val: v});
    endtask

    task automatic wait_cyc(input int t);
        while (pcyc < t) @(negedge clk50M);
    endtask

    task automatic do_reset(input int sp, input logic [1:0] md, output int r);
        sb_on = 1'b0;
        @(posedge clk50M);
        #1;
        rst      = 1'b0;
        speed    = CW'(sp);
        mode     = md;
        step_btn = 1'b0;
        repeat (3) @(posedge clk50M);
        #1;
        exp_q.delete();
        rises_seen = 0;
        rst        = 1'b1;
        sb_on      = 1'b1;
        r          = pcyc;
    endtask

    task automatic check_drained(input string name);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s: %0d expected clk_cpu edges never seen (next at cyc %0d), expected 0 left",
                     name, exp_q.size(), exp_q[0].cyc);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk50M);
        total += 3;
        if (clk_cpu !== 1'b0) begin
            bad++;
            $display("FAIL reset_clk_cpu: got %b, expected 0", clk_cpu);
        end
        if (rise_tick !== 1'b0) begin
            bad++;
            $display("FAIL reset_rise_tick: got %b, expected 0", rise_tick);
        end
        if (cycle_count !== 32'd0) begin
            bad++;
            $display("FAIL reset_cycle_count: got %0d, expected 0", cycle_count);
        end
    endtask

    // speed=3: first rise speed+1 cycles after release, then 4 high / 4 low.
    task automatic test_run();
        int r;
        do_reset(3, 2'b00, r);
        for (int i = 0; i < 10; i++) begin
            push_ev(r + 4 + 8 * i, 1'b1);
            push_ev(r + 8 + 8 * i, 1'b0);
        end
        wait_cyc(r + 80);
        total++;
        if (cycle_count !== cnt_model(10)) begin
            bad++;
            $display("FAIL run_count80: got %0d, expected %0d", cycle_count, cnt_model(10));
        end
        wait_cyc(r + 82);
        check_drained("run_edges");
    endtask

    // Halt two cycles into a high phase: the phase completes, then clk_cpu stays low.
    task automatic test_halt();
        int r, h;
        do_reset(5, 2'b00, r);
        h = r + 6;
        push_ev(h, 1'b1);
        wait_cyc(h + 2);
        mode = 2'b10;
        push_ev(h + 6, 1'b0);
        wait_cyc(h + 20);
        total++;
        if (clk_cpu !== 1'b0) begin
            bad++;
            $display("FAIL halt_level: got %b, expected 0", clk_cpu);
        end
        mode = 2'b00;
        // RUN entered at h+21 with cnt=0; rise speed+1 cycles after that.
        push_ev(h + 27, 1'b1);
        push_ev(h + 33, 1'b0);
        push_ev(h + 39, 1'b1);
        wait_cyc(h + 42);
        check_drained("halt_edges");
    endtask

    // Bouncing press, then a second press inside STEP_HI which must be ignored.
    task automatic test_step();
        int r, p, b;
        do_reset(30, 2'b01, r);
        p = r + 3;
        wait_cyc(p);
        step_btn = 1'b1;
        wait_cyc(p + 3);
        step_btn = 1'b0;
        wait_cyc(p + 6);
        step_btn = 1'b1;
        b = p + 6;
        push_ev(b + 12, 1'b1);
        push_ev(b + 43, 1'b0);
        wait_cyc(b + 12);
        step_btn = 1'b0;
        wait_cyc(b + 24);
        step_btn = 1'b1;
        wait_cyc(b + 50);
        step_btn = 1'b0;
        wait_cyc(b + 110);
        total++;
        if (cycle_count !== cnt_model(1)) begin
            bad++;
            $display("FAIL step_count: got %0d, expected %0d", cycle_count, cnt_model(1));
        end
        check_drained("step_edges");
    endtask

    // speed 20 -> 4 with cnt=15: toggle on the next edge, then 5-cycle half periods.
    task automatic test_speed_shrink();
        int r;
        do_reset(20, 2'b00, r);
        push_ev(r + 21, 1'b1);
        wait_cyc(r + 36);
        speed = CW'(4);
        push_ev(r + 37, 1'b0);
        push_ev(r + 42, 1'b1);
        push_ev(r + 47, 1'b0);
        push_ev(r + 52, 1'b1);
        push_ev(r + 57, 1'b0);
        wait_cyc(r + 60);
        check_drained("shrink_edges");
    endtask

    task automatic test_async_reset();
        int r, b, r2;
        do_reset(10, 2'b01, r);
        b = r + 2;
        wait_cyc(b);
        step_btn = 1'b1;
        push_ev(b + 12, 1'b1);
        wait_cyc(b + 15);
        total += 2;
        if (clk_cpu !== 1'b1) begin
            bad++;
            $display("FAIL step_hi_level: got %b, expected 1", clk_cpu);
        end
        if (cycle_count !== cnt_model(1)) begin
            bad++;
            $display("FAIL step_hi_count: got %0d, expected %0d", cycle_count, cnt_model(1));
        end
        check_drained("pre_reset_edges");
        #2;
        sb_on    = 1'b0;
        rst      = 1'b0;
        step_btn = 1'b0;
        #1;
        total += 3;
        if (clk_cpu !== 1'b0) begin
            bad++;
            $display("FAIL async_clk_cpu: got %b, expected 0", clk_cpu);
        end
        if (rise_tick !== 1'b0) begin
            bad++;
            $display("FAIL async_rise_tick: got %b, expected 0", rise_tick);
        end
        if (cycle_count !== 32'd0) begin
            bad++;
            $display("FAIL async_cycle_count: got %0d, expected 0", cycle_count);
        end
        do_reset(10, 2'b00, r2);
        push_ev(r2 + 11, 1'b1);
        push_ev(r2 + 22, 1'b0);
        push_ev(r2 + 33, 1'b1);
        wait_cyc(r2 + 36);
        check_drained("post_reset_edges");
    endtask

    initial begin
        rst      = 1'b1;
        speed    = CW'(3);
        mode     = 2'b00;
        step_btn = 1'b0;
        #2;
        rst = 1'b0;
        test_reset();
        test_run();
        test_halt();
        test_step();
        test_speed_shrink();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
